// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational word reads, sized big-endian word writes,
// and fixed-latency 256-bit block transfers that finish with a one-cycle ready pulse.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic [31:0]  DataAddress_IN,
  input  logic [31:0]  Data_IN,
  input  logic [1:0]   DataSize_IN,
  input  logic         MemRead_IN,
  input  logic         MemWrite_IN,
  output logic [31:0]  Data_OUT,
  input  logic         MemBlockRead_IN,
  input  logic         MemBlockWrite_IN,
  input  logic [255:0] DataBlock_IN,
  output logic [255:0] DataBlock_OUT,
  output logic         BlockReady_OUT,
  output logic         Busy_OUT
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned BLK_W = ADDR_WIDTH - 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [31:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] base_q, base_d;
  logic             op_write_q, op_write_d;
  logic [255:0]     wblock_q, wblock_d;
  logic [255:0]     rblock_q, rblock_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_off;
  logic [2:0]            size_n;
  logic [2:0]            lane_rel;
  logic [1:0]            lane_sel;
  logic [3:0]            ww_be;
  logic [31:0]           ww_data;
  logic                  finish_c;
  logic                  commit_c;
  logic                  snapshot_c;
  logic                  ww_in_blk_c;
  logic                  unused_addr;

  assign word_idx    = DataAddress_IN[ADDR_WIDTH+1:2];
  assign byte_off    = DataAddress_IN[1:0];
  assign unused_addr = ^DataAddress_IN[31:ADDR_WIDTH+2];
  assign size_n      = (DataSize_IN == 2'd0) ? 3'd4 : {1'b0, DataSize_IN};

  // Merge byte lanes (lane 0 = bits [31:24]) of new_w over old_w.
  function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [3:0] be,
                                           input logic [31:0] new_w);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[{~2'(k), 3'b000} +: 8] = new_w[{~2'(k), 3'b000} +: 8];
    end
    return r;
  endfunction

  // Store steering: lane b+j takes byte n-1-j of Data_IN; lanes past the word are dropped.
  always_comb begin
    ww_be    = '0;
    ww_data  = '0;
    lane_rel = '0;
    lane_sel = '0;
    for (int k = 0; k < 4; k++) begin
      lane_rel = 3'(k) - {1'b0, byte_off};
      lane_sel = 2'(size_n - 3'd1 - lane_rel);
      if ((3'(k) >= {1'b0, byte_off}) && (lane_rel < size_n)) begin
        ww_be[k]                            = 1'b1;
        ww_data[{~2'(k), 3'b000} +: 8]      = Data_IN[{lane_sel, 3'b000} +: 8];
      end
    end
  end

  assign finish_c    = (state_q == S_WAIT) && (cnt_q == '0);
  assign commit_c    = finish_c && op_write_q;
  assign snapshot_c  = finish_c && !op_write_q;
  assign ww_in_blk_c = MemWrite_IN && (word_idx[ADDR_WIDTH-1:3] == base_q);

  // SRAM: block commit first, a same-edge word write to a committed word is merged on top.
  always_ff @(posedge CLOCK) begin
    if (commit_c) begin
      for (int i = 0; i < 8; i++) begin
        mem[{base_q, 3'(i)}] <= apply_be(wblock_q[32*i +: 32],
                                         (ww_in_blk_c && (word_idx[2:0] == 3'(i))) ? ww_be : 4'b0,
                                         ww_data);
      end
    end
    if (MemWrite_IN && !(commit_c && ww_in_blk_c)) begin
      mem[word_idx] <= apply_be(mem[word_idx], ww_be, ww_data);
    end
  end

  assign Data_OUT = MemRead_IN ? mem[word_idx] : 32'h0;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      op_write_q <= 1'b0;
      wblock_q   <= '0;
      rblock_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      op_write_q <= op_write_d;
      wblock_q   <= wblock_d;
      rblock_q   <= rblock_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next state: accept only in IDLE, write wins over read.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    op_write_d = op_write_q;
    wblock_d   = wblock_q;
    unique case (state_q)
      S_IDLE: begin
        if (MemBlockWrite_IN || MemBlockRead_IN) begin
          state_d    = S_WAIT;
          cnt_d      = CNT_W'(LATENCY - 1);
          base_d     = DataAddress_IN[ADDR_WIDTH+1:5];
          op_write_d = MemBlockWrite_IN;
          if (MemBlockWrite_IN) wblock_d = DataBlock_IN;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: read snapshot includes any word write landing on the same edge.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    ready_d  = (state_d == S_DONE);
    rblock_d = rblock_q;
    if (snapshot_c) begin
      for (int i = 0; i < 8; i++) begin
        rblock_d[32*i +: 32] = apply_be(mem[{base_q, 3'(i)}],
                                        (ww_in_blk_c && (word_idx[2:0] == 3'(i))) ? ww_be : 4'b0,
                                        ww_data);
      end
    end
  end

  assign DataBlock_OUT  = rblock_q;
  assign BlockReady_OUT = ready_q;
  assign Busy_OUT       = busy_q;

endmodule
